// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//   Fetch stage for the multi-cycle CPU. Reads one byte per cycle from a
//   byte-wide memory, assembles 16-bit instructions low byte first (the low
//   byte sits at the lower address), and queues them for the control unit.
//   A flush discards everything queued or half-assembled and redirects
//   fetch to a new address.
//
// Handshake: Instr/Instr_PC/Instr_Valid come from registers only. A pop
//   happens at the rising edge where Instr_Valid && Instr_Ready. The head
//   entry holds still while Instr_Valid=1 and Instr_Ready=0. A transfer that
//   completes in a flush cycle counts as delivered.
//
// Ports:
//   Clock, Reset      rising-edge clock, asynchronous active-high reset
//   Mem_Address       byte address presented to memory (current fetch_pc)
//   Mem_CS            active-low chip select
//   Mem_WR            write enable, always 0
//   Mem_Data          combinational read data for Mem_Address
//   Flush, Flush_PC   discard the queue and restart fetch at Flush_PC
//   Instr, Instr_PC   head instruction {high, low} and its low-byte address
//   Instr_Valid       head entry is valid
//   Instr_Ready       consumer takes the head entry
//   Count             occupied entries
//   Fetch_State       current FSM state (0 = FETCH_L, 1 = FETCH_H)
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     Clock,
  input  logic                     Reset,
  output logic [15:0]              Mem_Address,
  output logic                     Mem_CS,
  output logic                     Mem_WR,
  input  logic [7:0]               Mem_Data,
  input  logic                     Flush,
  input  logic [15:0]              Flush_PC,
  output logic [15:0]              Instr,
  output logic [15:0]              Instr_PC,
  output logic                     Instr_Valid,
  input  logic                     Instr_Ready,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [0:0]               Fetch_State
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] FETCH_L = 1'b0;
  localparam logic [0:0] FETCH_H = 1'b1;

  logic [0:0]       state;
  logic [15:0]      fetch_pc;
  logic [7:0]       lo;
  logic [15:0]      lo_pc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      q_instr [DEPTH];
  logic [15:0]      q_pc    [DEPTH];

  logic full;
  logic do_lo;
  logic do_push;
  logic do_pop;

  // The space check happens only when a low byte is fetched; the slot it
  // reserves cannot be taken before the matching high byte arrives, so
  // FETCH_H never has to stall.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    do_lo   = (state == FETCH_L) && !full && !Flush;
    do_push = (state == FETCH_H) && !Flush;
    do_pop  = Instr_Valid && Instr_Ready;
  end

  assign Mem_Address = fetch_pc;
  assign Mem_CS      = Reset || !(do_lo || do_push);
  assign Mem_WR      = 1'b0;
  assign Instr_Valid = (count != '0);
  assign Instr       = q_instr[rd_ptr];
  assign Instr_PC    = q_pc[rd_ptr];
  assign Count       = count;
  assign Fetch_State = state;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= FETCH_L;
      fetch_pc <= RESET_PC;
      lo       <= '0;
      lo_pc    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (Flush) begin
      // A pop in this cycle has already been seen by the consumer; the
      // queue is emptied regardless.
      state    <= FETCH_L;
      fetch_pc <= Flush_PC;
      lo       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (do_lo) begin
        lo       <= Mem_Data;
        lo_pc    <= fetch_pc;
        fetch_pc <= fetch_pc + 16'd1;
        state    <= FETCH_H;
      end
      if (do_push) begin
        fetch_pc <= fetch_pc + 16'd1;
        wr_ptr   <= wr_ptr + PTR_W'(1);
        state    <= FETCH_L;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is reset so Instr/Instr_PC are never X.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (do_push) begin
      q_instr[wr_ptr] <= {Mem_Data, lo};
      q_pc[wr_ptr]    <= lo_pc;
    end
  end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Upstream fetch stage for the multi-cycle CPU.
- Streams bytes from byte-wide memory at a fetch PC and assembles 16-bit instructions, low byte first (LSB at the lower address), matching the IR_LH=0 / IR_LH=1 load order.
- Buffers assembled instructions in a small FIFO and presents them to the control unit with a valid/ready handshake.
- Supports flush-and-redirect for BRA/BNE/BEQ/CALL/RET.

Parameters:
- DEPTH, 4: FIFO entries (16-bit instructions); power of two, at least 2.
- RESET_PC, 16'h0000: fetch address after reset.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Mem_Address  output  16  byte address to memory
- Mem_CS  output  1  memory chip select, active-low (0 = enabled)
- Mem_WR  output  1  write enable; tied to 0 (read-only port)
- Mem_Data  input  8  read data; combinational, valid in the same cycle as Mem_Address while Mem_CS=0
- Flush  input  1  discard queued/partial instructions and redirect fetch
- Flush_PC  input  16  new fetch address, sampled when Flush=1
- Instr  output  16  head-of-queue instruction {high byte, low byte}
- Instr_PC  output  16  address of the head instruction's low byte
- Instr_Valid  output  1  head entry is valid
- Instr_Ready  input  1  consumer accepts the head entry
- Count  output  clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset (asynchronous): state=FETCH_L, fetch_pc=RESET_PC, count=0, read/write pointers=0, low-byte latch=0.
  - While Reset=1: Mem_CS=1, Mem_WR=0, Mem_Address=RESET_PC, Instr_Valid=0, Count=0. Instr and Instr_PC are don't-care but must not be X after the first push.
- FSM with two states:
  - FETCH_L:
    - If count<DEPTH and Flush=0: Mem_CS=0, Mem_Address=fetch_pc.
    - At the clock edge: latch lo=Mem_Data, lo_pc=fetch_pc, fetch_pc=fetch_pc+1, go to FETCH_H.
    - Otherwise: Mem_CS=1, hold state.
  - FETCH_H:
    - If Flush=0: Mem_CS=0, Mem_Address=fetch_pc.
    - At the clock edge: push {Mem_Data, lo} with lo_pc, fetch_pc=fetch_pc+1, go to FETCH_L.
    - FETCH_H never stalls. The space check was made in FETCH_L, and pops only free entries.
- Fetch rate: one byte per cycle, one instruction every 2 cycles.
  - First Instr_Valid=1 appears after the 2nd rising edge following Reset release.
- Handshake:
  - Instr_Valid = (count != 0), derived from registers only.
  - A pop occurs at the edge where Instr_Valid & Instr_Ready.
  - Instr and Instr_PC are stable while Valid=1 and Ready=0.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Pop when empty: ignored.
- fetch_pc is 16-bit and wraps 16'hFFFF -> 16'h0000.
  - An instruction whose low byte is at FFFF takes its high byte from 0000, with Instr_PC=16'hFFFF.
- Flush has top priority:
  - In the Flush=1 cycle, Mem_CS=1 (no memory access).
  - At the edge: count=0, pointers=0, any partial low byte discarded, fetch_pc=Flush_PC, state=FETCH_L.
  - A handshake completing in the flush cycle counts as delivered to the consumer; the queue is still cleared.
  - Instr_Valid=0 from the cycle after the flush until the first post-flush push, 2 edges after Flush drops.
  - Back-to-back Flush cycles: the last Flush_PC wins.
- Mem_WR is always 0. The block never drives a write.
- Reset mid-fetch (including in FETCH_H): partial instruction lost, full reset state applied immediately.

Test Plan:
- Preload memory[0..5]=11,22,33,44,55,66; release Reset with Ready=1 -> Instr=2211/PC 0000 valid after edge 2, then 4433/PC 0002, 6655/PC 0004, each exactly 2 cycles apart.
- Ready=0 from reset -> Count reaches DEPTH (4) after 8 edges, Mem_CS=1 while in FETCH_L and full, fetch_pc=0008. Raise Ready -> entries drain in order 2211,4433,6655,... with no loss or duplication.
- Ready held 1 with DEPTH=4 steady stream -> Count alternates between 0 and 1 only, never exceeds 1; simultaneous push/pop cycles leave Count unchanged.
- Flush=1, Flush_PC=0040 while in FETCH_H with 2 entries queued -> next cycle Count=0, Valid=0; first post-flush Instr={mem[41],mem[40]}, PC=0040; Mem_Address never shows the pre-flush address after the flush edge.
- Flush_PC=FFFF, mem[FFFF]=AB, mem[0000]=CD -> Instr=CDAB, Instr_PC=FFFF, next Instr_PC=0001.
- Assert Reset asynchronously mid-cycle while in FETCH_H with Count=3 -> Count=0, Instr_Valid=0, Mem_CS=1 immediately; after release, fetch restarts at RESET_PC.
